isqrt_share_arbiter: RTL and testbench

Shares one fixed-latency pipelined `isqrt` instance between `N_REQ` independent requesters. Each cycle the block grants at most one requester, drives the argument into `isqrt`, and records the requester index in a tag shift register aligned to the `isqrt` latency. Results are routed back to the originating requester. The block sits between formula-level FSMs and the single `isqrt` instance in the top-level wrapper.

---
 rtl/isqrt_share_arb_pkg.sv | 15 +
 rtl/isqrt_share_rr_pick.sv | 43 ++++
 rtl/isqrt_share_arbiter.sv | 167 ++++++++++++++++
 tb/tb_isqrt_share_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/isqrt_share_arb_pkg.sv
// Shared widths, limits and tag type for the isqrt share arbiter.
package isqrt_share_arb_pkg;

    localparam int unsigned ARG_W     = 32;
    localparam int unsigned RES_W     = 16;
    localparam int unsigned N_REQ_MAX = 8;
    localparam int unsigned IDX_W     = $clog2(N_REQ_MAX);

    // One tag-pipe stage: valid plus the requester index that issued it.
    typedef struct packed {
        logic             vld;
        logic [IDX_W-1:0] idx;
    } tag_t;

endpackage

// File: rtl/isqrt_share_rr_pick.sv
// Combinational one-hot priority picker.
// ISQRT_SHARE_ARB_RR_EN defined: search starts at ptr and wraps around.
// ISQRT_SHARE_ARB_RR_EN undefined: fixed priority, lowest index wins, ptr ignored.
module isqrt_share_rr_pick
    import isqrt_share_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 2
)
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt
);

`ifdef ISQRT_SHARE_ARB_RR_EN
    localparam int unsigned SEL_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    // First valid requester at or after ptr, with wrap-around.
    always_comb begin
        logic [SEL_W-1:0] pos;
        logic             found;
        gnt   = '0;
        found = 1'b0;
        pos   = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            pos = SEL_W'((32'(ptr) + k) % N_REQ);
            if (!found && req[pos]) begin
                gnt[pos] = 1'b1;
                found    = 1'b1;
            end
        end
    end
`else
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    // Isolate the lowest set request bit.
    always_comb begin
        gnt = req & (~req + N_REQ'(1));
    end
`endif

endmodule

// File: rtl/isqrt_share_arbiter.sv
// Shares one fixed-latency pipelined isqrt between N_REQ requesters and routes
// each result back to its issuer via a latency-aligned tag pipe.
// Optional macro: ISQRT_SHARE_ARB_RR_EN selects round-robin over fixed priority.
module isqrt_share_arbiter
    import isqrt_share_arb_pkg::*;
#(
    parameter int unsigned N_REQ     = 2,
    parameter int unsigned ISQRT_LAT = 4
)
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_vld,
    input  logic [N_REQ*ARG_W-1:0] req_x,
    output logic [N_REQ-1:0]       req_rdy,
    output logic [N_REQ-1:0]       rsp_vld,
    output logic [RES_W-1:0]       rsp_y,
    output logic                   isqrt_x_vld,
    output logic [ARG_W-1:0]       isqrt_x,
    input  logic                   isqrt_y_vld,
    input  logic [RES_W-1:0]       isqrt_y,
    output logic                   err
);

    logic [N_REQ-1:0] gnt;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] gnt_idx;
    logic [ARG_W-1:0] sel_x;
    logic             transfer;

    logic             isqrt_x_vld_q, isqrt_x_vld_d;
    logic [ARG_W-1:0] isqrt_x_q, isqrt_x_d;
    logic [IDX_W-1:0] issue_idx_q, issue_idx_d;

    tag_t             tag_q [ISQRT_LAT];
    tag_t             tag_out;

    logic [N_REQ-1:0] rsp_vld_q, rsp_vld_d;
    logic [RES_W-1:0] rsp_y_q, rsp_y_d;
    logic             err_q, err_d;
    logic             hit;
    logic             mismatch;

    isqrt_share_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req (req_vld),
        .ptr (ptr),
        .gnt (gnt)
    );

`ifdef ISQRT_SHARE_ARB_RR_EN
    logic [IDX_W-1:0] prio_ptr_q, prio_ptr_d;

    // Pointer moves just past the requester that transferred.
    always_comb begin
        prio_ptr_d = prio_ptr_q;
        if (transfer) begin
            prio_ptr_d = IDX_W'((32'(gnt_idx) + 32'd1) % N_REQ);
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prio_ptr_q <= '0;
        end else begin
            prio_ptr_q <= prio_ptr_d;
        end
    end

    assign ptr = prio_ptr_q;
`else
    assign ptr = '0;
`endif

    // Grant is suppressed while reset is held; a grant always implies a transfer.
    assign req_rdy  = rst ? gnt : '0;
    assign transfer = |req_rdy;

    // Encode the winner and select its argument.
    always_comb begin
        gnt_idx = '0;
        sel_x   = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                gnt_idx = IDX_W'(i);
                sel_x   = req_x[i*ARG_W +: ARG_W];
            end
        end
    end

    // Issue stage next-state: argument and index hold when idle.
    always_comb begin
        isqrt_x_vld_d = transfer;
        isqrt_x_d     = isqrt_x_q;
        issue_idx_d   = issue_idx_q;
        if (transfer) begin
            isqrt_x_d   = sel_x;
            issue_idx_d = gnt_idx;
        end
    end

    // Issue stage registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            isqrt_x_vld_q <= 1'b0;
            isqrt_x_q     <= '0;
            issue_idx_q   <= '0;
        end else begin
            isqrt_x_vld_q <= isqrt_x_vld_d;
            isqrt_x_q     <= isqrt_x_d;
            issue_idx_q   <= issue_idx_d;
        end
    end

    // Tag pipe: tracks which requester owns each isqrt stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned s = 0; s < ISQRT_LAT; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            tag_q[0] <= {isqrt_x_vld_q, issue_idx_q};
            for (int unsigned s = 1; s < ISQRT_LAT; s++) begin
                tag_q[s] <= tag_q[s-1];
            end
        end
    end

    assign tag_out  = tag_q[ISQRT_LAT-1];
    assign hit      = isqrt_y_vld & tag_out.vld;
    assign mismatch = isqrt_y_vld ^ tag_out.vld;

    // Return routing; a misaligned result is dropped and flagged.
    always_comb begin
        rsp_vld_d = '0;
        rsp_y_d   = rsp_y_q;
        err_d     = err_q | mismatch;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            rsp_vld_d[i] = hit && (tag_out.idx == IDX_W'(i));
        end
        if (hit) begin
            rsp_y_d = isqrt_y;
        end
    end

    // Return and error registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_vld_q <= '0;
            rsp_y_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            rsp_vld_q <= rsp_vld_d;
            rsp_y_q   <= rsp_y_d;
            err_q     <= err_d;
        end
    end

    assign isqrt_x_vld = isqrt_x_vld_q;
    assign isqrt_x     = isqrt_x_q;
    assign rsp_vld     = rsp_vld_q;
    assign rsp_y       = rsp_y_q;
    assign err         = err_q;

endmodule

// File: tb/tb_isqrt_share_arbiter.sv
// Randomised self-checking bench for isqrt_share_arbiter with a behavioural isqrt.
module tb_isqrt_share_arbiter;

    localparam int unsigned N   = 2;
    localparam int unsigned LAT = 4;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req_vld;
    logic [N*32-1:0] req_x;
    logic [N-1:0]    req_rdy;
    logic [N-1:0]    rsp_vld;
    logic [15:0]     rsp_y;
    logic            isqrt_x_vld;
    logic [31:0]     isqrt_x;
    logic            isqrt_y_vld;
    logic [15:0]     isqrt_y;
    logic            err;

    isqrt_share_arbiter #(
        .N_REQ     (N),
        .ISQRT_LAT (LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_vld     (req_vld),
        .req_x       (req_x),
        .req_rdy     (req_rdy),
        .rsp_vld     (rsp_vld),
        .rsp_y       (rsp_y),
        .isqrt_x_vld (isqrt_x_vld),
        .isqrt_x     (isqrt_x),
        .isqrt_y_vld (isqrt_y_vld),
        .isqrt_y     (isqrt_y),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] ref_sqrt(input logic [31:0] x);
        longint lo;
        longint hi;
        longint mid;
        lo = 0;
        hi = 65535;
        while (lo < hi) begin
            mid = (lo + hi + 1) / 2;
            if (mid * mid <= longint'(x)) lo = mid;
            else hi = mid - 1;
        end
        return 16'(lo);
    endfunction

    // Behavioural isqrt: fixed latency, reset together with the arbiter.
    logic        m_vld [LAT];
    logic [15:0] m_y   [LAT];
    logic        inject;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < LAT; s++) begin
                m_vld[s] <= 1'b0;
                m_y[s]   <= 16'h0;
            end
        end else begin
            m_vld[0] <= isqrt_x_vld;
            m_y[0]   <= ref_sqrt(isqrt_x);
            for (int s = 1; s < LAT; s++) begin
                m_vld[s] <= m_vld[s-1];
                m_y[s]   <= m_y[s-1];
            end
        end
    end

    assign isqrt_y_vld = m_vld[LAT-1] | inject;
    assign isqrt_y     = m_y[LAT-1];

    // Reference model state.
    typedef struct {
        int          due;
        int          idx;
        logic [15:0] y;
    } exp_t;

    exp_t        exp_q[$];
    logic [N-1:0] pend;
    logic [31:0] px [N];
    int          exp_ptr;
    logic        exp_xv;
    logic [31:0] exp_x;
    logic        exp_err;
    int          cyc;
    int          n_checks;
    int          n_fail;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Fixed priority behaves as a search that always starts at 0.
    function automatic int pick_winner(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    // One clock cycle: drive at negedge, check grant, advance, check outputs.
    task automatic run_cycle();
        logic [N-1:0] exp_rdy;
        logic [N-1:0] exp_rv;
        exp_t         e;
        int           w;
        req_vld = pend;
        for (int i = 0; i < N; i++) req_x[i*32 +: 32] = px[i];
        #1;
        w       = pick_winner(pend, exp_ptr);
        exp_rdy = '0;
        if (w >= 0) exp_rdy[w] = 1'b1;
        check("req_rdy", 32'(req_rdy), 32'(exp_rdy));
        @(posedge clk);
        if (w >= 0) begin
            exp_q.push_back('{due: cyc + LAT + 2, idx: w, y: ref_sqrt(px[w])});
            exp_xv  = 1'b1;
            exp_x   = px[w];
            pend[w] = 1'b0;
`ifdef ISQRT_SHARE_ARB_RR_EN
            exp_ptr = (w + 1) % N;
`endif
        end else begin
            exp_xv = 1'b0;
        end
        if (inject) exp_err = 1'b1;
        cyc++;
        @(negedge clk);
        inject = 1'b0;
        exp_rv = '0;
        e      = '{due: 0, idx: 0, y: 16'h0};
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            exp_rv[e.idx] = 1'b1;
        end
        check("rsp_vld", 32'(rsp_vld), 32'(exp_rv));
        if (exp_rv != '0) check("rsp_y", 32'(rsp_y), 32'(e.y));
        check("isqrt_x_vld", 32'(isqrt_x_vld), 32'(exp_xv));
        check("isqrt_x", isqrt_x, exp_x);
        check("err", 32'(err), 32'(exp_err));
    endtask

    // Asynchronous reset with immediate checks of reset values.
    task automatic do_reset();
        @(negedge clk);
        req_vld = '1;
        rst     = 1'b0;
        #1;
        check("rst_req_rdy", 32'(req_rdy), 32'd0);
        check("rst_isqrt_x_vld", 32'(isqrt_x_vld), 32'd0);
        check("rst_isqrt_x", isqrt_x, 32'd0);
        check("rst_rsp_vld", 32'(rsp_vld), 32'd0);
        check("rst_rsp_y", 32'(rsp_y), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst     = 1'b1;
        req_vld = '0;
        exp_q.delete();
        pend    = '0;
        exp_ptr = 0;
        exp_xv  = 1'b0;
        exp_x   = 32'h0;
        exp_err = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) run_cycle();
    endtask

    initial begin
        rst      = 1'b0;
        req_vld  = '0;
        req_x    = '0;
        inject   = 1'b0;
        pend     = '0;
        for (int i = 0; i < N; i++) px[i] = 32'h0;
        exp_ptr  = 0;
        exp_xv   = 1'b0;
        exp_x    = 32'h0;
        exp_err  = 1'b0;
        cyc      = 0;
        n_checks = 0;
        n_fail   = 0;

        do_reset();

        // Single request.
        pend[0] = 1'b1;
        px[0]   = 32'd16;
        run_cycle();
        idle(LAT + 3);

        // Two requesters contending at once.
        pend  = 2'b11;
        px[0] = 32'd100;
        px[1] = 32'd81;
        idle(LAT + 5);

        // Both requesters continuously valid for four cycles.
        px[1] = 32'd49;
        for (int i = 0; i < 4; i++) begin
            pend  = 2'b11;
            px[0] = $urandom;
            run_cycle();
        end
        idle(LAT + 5);

        // Boundary arguments on both requesters.
        pend  = 2'b11;
        px[0] = 32'hFFFF_FFFF;
        px[1] = 32'h0;
        idle(LAT + 5);
        pend  = 2'b11;
        px[0] = 32'h0;
        px[1] = 32'hFFFF_FFFF;
        idle(LAT + 5);

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 99) < 65) begin
                    pend[i] = 1'b1;
                    case ($urandom_range(0, 7))
                        0:       px[i] = 32'h0;
                        1:       px[i] = 32'hFFFF_FFFF;
                        2:       px[i] = 32'($urandom_range(0, 1000));
                        default: px[i] = $urandom;
                    endcase
                end
            end
            run_cycle();
        end
        pend = '0;
        idle(LAT + 5);

        // Result with nothing in flight: sticky error, no response.
        inject = 1'b1;
        run_cycle();
        idle(6);

        do_reset();
        idle(2);

        // Reset two cycles after an issue drops the in-flight result.
        pend[1] = 1'b1;
        px[1]   = 32'd50;
        run_cycle();
        idle(2);
        do_reset();
        idle(LAT + 6);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
